// File: rtl/pwm_multi_if.sv
// Register-side bus of the multi-channel PWM: run enable, period/width load and status.
// The register block drives the master side; pwm_multi is the slave.
interface pwm_multi_if #(
  parameter int W = 16,
  parameter int N = 3
);
  logic           en;
  logic [W-1:0]   period;
  logic [N*W-1:0] width;
  logic           load;
  logic [N-1:0]   pwm;
  logic           period_end;
  logic           pending;

  modport master (output en, period, width, load, input pwm, period_end, pending);
  modport slave  (input en, period, width, load, output pwm, period_end, pending);
endinterface

// File: rtl/pwm_multi.sv
// N-channel PWM sharing one W-bit counter, edge- or center-aligned, with shadowed
// period/width registers that take effect only at a period boundary.
//
// dir state | meaning
// DIR_UP    | counting up (always the case in edge mode and while disabled)
// DIR_DN    | center mode, counting down from P toward 0
module pwm_multi #(
  parameter int W      = 16,
  parameter int N      = 3,
  parameter int CENTER = 0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  pwm_multi_if.slave bus
);

  localparam logic [0:0]   DIR_UP = 1'b0;
  localparam logic [0:0]   DIR_DN = 1'b1;
  localparam logic [W-1:0] ONE    = W'(1);

  logic [W-1:0]   cnt_q, cnt_d;
  logic [0:0]     dir_q, dir_d;
  logic [W-1:0]   per_act_q, per_act_d;
  logic [N*W-1:0] wid_act_q, wid_act_d;
  logic [W-1:0]   per_sh_q, per_sh_d;
  logic [N*W-1:0] wid_sh_q, wid_sh_d;
  logic           pending_q, pending_d;
  logic [N-1:0]   pwm_q, pwm_d;
  logic           pe_q, pe_d;
  logic           bnd;
  logic           apply;

  always_comb begin
    bnd   = (CENTER != 0) ? (cnt_q == '0) : (cnt_q >= per_act_q);
    // Disabled counts as a boundary so loads while stopped land in the active set at once.
    apply = ~bus.en | bnd;

    per_sh_d  = per_sh_q;
    wid_sh_d  = wid_sh_q;
    per_act_d = per_act_q;
    wid_act_d = wid_act_q;
    pending_d = pending_q;

    if (bus.load) begin
      per_sh_d = bus.period;
      wid_sh_d = bus.width;
    end

    if (apply) begin
      pending_d = 1'b0;
      if (bus.load) begin
        per_act_d = bus.period;
        wid_act_d = bus.width;
      end else if (pending_q) begin
        per_act_d = per_sh_q;
        wid_act_d = wid_sh_q;
      end
    end else if (bus.load) begin
      pending_d = 1'b1;
    end

    cnt_d = '0;
    dir_d = DIR_UP;
    if (bus.en) begin
      if (CENTER == 0) begin
        if (!bnd) cnt_d = cnt_q + ONE;
      end else if (per_act_d != '0) begin
        // Leaving cnt==0 already uses the period that takes effect on this edge.
        if (cnt_q == '0) begin
          cnt_d = ONE;
        end else if (dir_q == DIR_DN || cnt_q >= per_act_q) begin
          cnt_d = cnt_q - ONE;
          dir_d = DIR_DN;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
    end

    pe_d = bus.en & bnd;
    for (int i = 0; i < N; i++) begin
      pwm_d[i] = bus.en & (cnt_q < wid_act_q[i*W +: W]);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      dir_q     <= DIR_UP;
      per_act_q <= '0;
      wid_act_q <= '0;
      per_sh_q  <= '0;
      wid_sh_q  <= '0;
      pending_q <= 1'b0;
      pwm_q     <= '0;
      pe_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      per_act_q <= per_act_d;
      wid_act_q <= wid_act_d;
      per_sh_q  <= per_sh_d;
      wid_sh_q  <= wid_sh_d;
      pending_q <= pending_d;
      pwm_q     <= pwm_d;
      pe_q      <= pe_d;
    end
  end

  assign bus.pwm        = pwm_q;
  assign bus.period_end = pe_q;
  assign bus.pending    = pending_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Drives an edge-aligned and a center-aligned pwm_multi with the same stimulus and
// checks both every cycle against a phase-based model, plus directed waveform counts.
module tb_pwm_multi;
  localparam int W = 8;
  localparam int N = 3;

  logic clk = 1'b0;
  logic rst_s = 1'b1;
  always #5 clk = ~clk;

  logic           en_s  = 1'b0;
  logic           ld_s  = 1'b0;
  logic [W-1:0]   per_s = '0;
  logic [N*W-1:0] wid_s = '0;

  pwm_multi_if #(.W(W), .N(N)) bus_e ();
  pwm_multi_if #(.W(W), .N(N)) bus_c ();

  assign bus_e.en = en_s;  assign bus_e.load = ld_s;
  assign bus_e.period = per_s;  assign bus_e.width = wid_s;
  assign bus_c.en = en_s;  assign bus_c.load = ld_s;
  assign bus_c.period = per_s;  assign bus_c.width = wid_s;

  pwm_multi #(.W(W), .N(N), .CENTER(0)) dut_e (.clk_i(clk), .rst_i(rst_s), .bus(bus_e));
  pwm_multi #(.W(W), .N(N), .CENTER(1)) dut_c (.clk_i(clk), .rst_i(rst_s), .bus(bus_c));

  int checks = 0;
  int failures = 0;

  // Model state per mode (0 edge, 1 center): phase within the period, active/shadow values.
  int           m_t[2];
  int           m_pa[2];
  int           m_ps[2];
  int           m_wa[2][N];
  int           m_ws[2][N];
  bit           m_pend[2];
  logic [N-1:0] e_pwm[2];
  logic         e_pe[2];

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N*W-1:0] pk(int a, int b, int c);
    return {W'(c), W'(b), W'(a)};
  endfunction

  function automatic void model_reset();
    for (int m = 0; m < 2; m++) begin
      m_t[m] = 0; m_pa[m] = 0; m_ps[m] = 0; m_pend[m] = 1'b0;
      e_pwm[m] = '0; e_pe[m] = 1'b0;
      for (int i = 0; i < N; i++) begin
        m_wa[m][i] = 0; m_ws[m][i] = 0;
      end
    end
  endfunction

  function automatic void model_step(int m);
    int p, t, cnt;
    bit bnd;
    p   = m_pa[m];
    t   = m_t[m];
    cnt = (m == 0) ? t : ((t <= p) ? t : 2*p - t);
    bnd = (m == 0) ? (t == p) : (t == 0);
    for (int i = 0; i < N; i++) e_pwm[m][i] = en_s && (cnt < m_wa[m][i]);
    e_pe[m] = en_s && bnd;
    if (!en_s || bnd) begin
      if (ld_s) begin
        m_pa[m] = int'(per_s);
        for (int i = 0; i < N; i++) m_wa[m][i] = int'(wid_s[i*W +: W]);
      end else if (m_pend[m]) begin
        m_pa[m] = m_ps[m];
        for (int i = 0; i < N; i++) m_wa[m][i] = m_ws[m][i];
      end
      m_pend[m] = 1'b0;
    end else if (ld_s) begin
      m_pend[m] = 1'b1;
    end
    if (ld_s) begin
      m_ps[m] = int'(per_s);
      for (int i = 0; i < N; i++) m_ws[m][i] = int'(wid_s[i*W +: W]);
    end
    if (!en_s)       t = 0;
    else if (m == 0) t = bnd ? 0 : t + 1;
    else if (bnd)    t = (m_pa[m] == 0) ? 0 : 1;
    else             t = (t + 1 == 2*p) ? 0 : t + 1;
    m_t[m] = t;
  endfunction

  // One clock: check last edge's outputs against the model, then drive the next inputs.
  task automatic step(bit en, bit ld, int p, logic [N*W-1:0] w);
    @(negedge clk);
    chk("pwm_edge", int'(bus_e.pwm), int'(e_pwm[0]));
    chk("pend_edge", int'(bus_e.period_end), int'(e_pe[0]));
    chk("pending_edge", int'(bus_e.pending), int'(m_pend[0]));
    chk("pwm_center", int'(bus_c.pwm), int'(e_pwm[1]));
    chk("pend_center", int'(bus_c.period_end), int'(e_pe[1]));
    chk("pending_center", int'(bus_c.pending), int'(m_pend[1]));
    en_s = en; ld_s = ld; per_s = W'(p); wid_s = w;
    model_step(0);
    model_step(1);
  endtask

  initial begin
    int hi0, hi1, hi2, pe_n, n;
    logic [N*W-1:0] wa, wb, wc, wd;
    wa = pk(0, 5, 10);
    wb = pk(0, 2, 10);
    wc = pk(0, 3, 10);
    wd = pk(0, 2, 5);

    model_reset();
    #3;
    chk("rst_pwm", int'(bus_e.pwm), 0);
    chk("rst_pe", int'(bus_e.period_end), 0);
    chk("rst_pending", int'(bus_c.pending), 0);
    @(posedge clk); #1 rst_s = 1'b0;

    // Edge P=9, widths {0,5,10}: 20 clocks = two periods.
    step(1'b0, 1'b1, 9, wa);
    step(1'b1, 1'b0, 9, wa);
    hi0 = 0; hi1 = 0; hi2 = 0; pe_n = 0;
    repeat (20) begin
      step(1'b1, 1'b0, 9, wa);
      hi0 += int'(bus_e.pwm[0]); hi1 += int'(bus_e.pwm[1]);
      hi2 += int'(bus_e.pwm[2]); pe_n += int'(bus_e.period_end);
    end
    chk("t1_ch0_high", hi0, 0);
    chk("t1_ch1_high", hi1, 10);
    chk("t1_ch2_high", hi2, 20);
    chk("t1_period_ends", pe_n, 2);

    // Load mid-period at cnt=3: pending until cnt=9, then 5-clock periods.
    n = 0;
    while (m_t[0] != 3 && n < 40) begin step(1'b1, 1'b0, 9, wa); n++; end
    chk("t2_sync", m_t[0], 3);
    step(1'b1, 1'b1, 4, wb);
    step(1'b1, 1'b0, 4, wb);
    chk("t2_pending_set", int'(bus_e.pending), 1);
    n = 0;
    do begin step(1'b1, 1'b0, 4, wb); n++; end while (!bus_e.period_end && n < 30);
    chk("t2_cycles_to_boundary", n, 6);
    hi1 = 0; pe_n = 0;
    repeat (10) begin
      step(1'b1, 1'b0, 4, wb);
      hi1 += int'(bus_e.pwm[1]); pe_n += int'(bus_e.period_end);
    end
    chk("t2_ch1_high", hi1, 4);
    chk("t2_period_ends", pe_n, 2);
    chk("t2_pending_clear", int'(bus_e.pending), 0);

    // Load in the boundary cycle: applies on that edge, pending never set.
    n = 0;
    while (m_t[0] != 4 && n < 20) begin step(1'b1, 1'b0, 4, wb); n++; end
    chk("t3_sync", m_t[0], 4);
    step(1'b1, 1'b1, 6, wc);
    step(1'b1, 1'b0, 6, wc);
    chk("t3_boundary_pe", int'(bus_e.period_end), 1);
    chk("t3_no_pending", int'(bus_e.pending), 0);
    hi1 = 0; pe_n = 0;
    repeat (7) begin
      step(1'b1, 1'b0, 6, wc);
      hi1 += int'(bus_e.pwm[1]); pe_n += int'(bus_e.period_end);
    end
    chk("t3_ch1_high", hi1, 3);
    chk("t3_period_ends", pe_n, 1);

    // Disable mid-period, then re-enable: first period_end after P+1 clocks.
    n = 0;
    while (m_t[0] != 3 && n < 20) begin step(1'b1, 1'b0, 6, wc); n++; end
    step(1'b0, 1'b0, 6, wc);
    step(1'b0, 1'b0, 6, wc);
    chk("t4_pwm_off", int'(bus_e.pwm), 0);
    chk("t4_no_pe", int'(bus_e.period_end), 0);
    step(1'b1, 1'b0, 6, wc);
    n = 0;
    do begin step(1'b1, 1'b0, 6, wc); n++; end while (!bus_e.period_end && n < 30);
    chk("t4_first_period", n, 7);

    // Center-aligned P=4, widths {0,2,5}: 16 clocks = two periods.
    step(1'b0, 1'b1, 4, wd);
    step(1'b1, 1'b0, 4, wd);
    hi0 = 0; hi1 = 0; hi2 = 0; pe_n = 0;
    repeat (16) begin
      step(1'b1, 1'b0, 4, wd);
      hi0 += int'(bus_c.pwm[0]); hi1 += int'(bus_c.pwm[1]);
      hi2 += int'(bus_c.pwm[2]); pe_n += int'(bus_c.period_end);
    end
    chk("t5_ch0_high", hi0, 0);
    chk("t5_ch1_high", hi1, 6);
    chk("t5_ch2_high", hi2, 16);
    chk("t5_period_ends", pe_n, 2);

    // Async reset between edges with pending set and outputs high.
    n = 0;
    while ((m_t[1] == 0 || m_t[0] == 4) && n < 20) begin step(1'b1, 1'b0, 4, wd); n++; end
    step(1'b1, 1'b1, 4, wd);
    step(1'b1, 1'b0, 4, wd);
    chk("t6_pending_before", int'(bus_c.pending), 1);
    #2 rst_s = 1'b1;
    #1;
    chk("t6_pwm_e", int'(bus_e.pwm), 0);
    chk("t6_pwm_c", int'(bus_c.pwm), 0);
    chk("t6_pe_c", int'(bus_c.period_end), 0);
    chk("t6_pending_e", int'(bus_e.pending), 0);
    chk("t6_pending_c", int'(bus_c.pending), 0);
    model_reset();
    @(posedge clk); #1 rst_s = 1'b0;
    repeat (6) step(1'b1, 1'b0, 4, wd);
    chk("t6_active_cleared", int'(bus_c.pwm), 0);

    // Randomized traffic against the model.
    repeat (800) begin
      step($urandom_range(0, 15) != 0, $urandom_range(0, 5) == 0, $urandom_range(0, 12),
           pk($urandom_range(0, 14), $urandom_range(0, 14), $urandom_range(0, 14)));
    end
    step(1'b1, 1'b0, 0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
